// File: rtl/layer11_bias_relu_acc.sv
// Per-lane multi-pass accumulator with bias add, 18-bit saturation and ReLU for layer 11.
// Latency: the last beat is accepted at edge E and out_valid rises after edge E+1.
// Backpressure: psum_ready stays low from the last beat until the output handshake completes.
module layer11_bias_relu_acc #(
  parameter int N_adder_tree = 16,
  parameter int MAX_PASSES   = 16,
  parameter int ACC_W        = 23
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_adder_tree*18-1:0]   bias_in,
  input  logic [N_adder_tree*18-1:0]   psum_in,
  input  logic                         psum_valid,
  input  logic                         psum_last,
  output logic                         psum_ready,
  output logic [N_adder_tree*18-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_overrun
);

  localparam int CNT_W = $clog2(MAX_PASSES) + 1;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(131071);

  typedef enum logic [1:0] {ACCUM, FINISH, OUTPUT} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         beat_cnt;
  logic signed [ACC_W-1:0]  acc     [N_adder_tree];
  logic signed [ACC_W-1:0]  acc_inc [N_adder_tree];
  logic [N_adder_tree*18-1:0] relu_dat;
  logic                     beat_acc;
  logic                     cnt_max;

  assign beat_acc = psum_valid && psum_ready;
  assign cnt_max  = (beat_cnt == CNT_W'(MAX_PASSES - 1));

  // Clamping below at -131072 and then applying ReLU both collapse to zero for negatives.
  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    logic signed [17:0]    psum_l;
    logic signed [17:0]    bias_l;
    logic signed [ACC_W:0] sum;
    assign psum_l     = psum_in[18*g +: 18];
    assign bias_l     = bias_in[18*g +: 18];
    assign acc_inc[g] = acc[g] + {{(ACC_W-18){psum_l[17]}}, psum_l};
    assign sum        = {acc[g][ACC_W-1], acc[g]} + {{(ACC_W-17){bias_l[17]}}, bias_l};
    assign relu_dat[18*g +: 18] = sum[ACC_W]     ? 18'd0 :
                                  (sum > SAT_MAX) ? 18'h1ffff : sum[17:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat_acc && (psum_last || cnt_max)) state_nxt = FINISH;
      FINISH:  state_nxt = OUTPUT;
      OUTPUT:  if (out_valid && out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    psum_ready = (state == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_adder_tree; i++) acc[i] <= '0;
      beat_cnt    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat_acc) begin
            for (int i = 0; i < N_adder_tree; i++) acc[i] <= acc_inc[i];
            beat_cnt <= beat_cnt + 1'b1;
            if (cnt_max && !psum_last) err_overrun <= 1'b1;
          end
        end
        FINISH: begin
          out_data  <= relu_dat;
          out_valid <= 1'b1;
          for (int i = 0; i < N_adder_tree; i++) acc[i] <= '0;
          beat_cnt  <= '0;
        end
        OUTPUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer11_bias_relu_acc.sv
// Directed bench for layer11_bias_relu_acc with hand-computed lane results.
// Bias bank: lane0=8836, lane3=-1948, all other lanes 0, constant for the whole run.
module tb_layer11_bias_relu_acc;

  localparam int N = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*18-1:0] bias_in;
  logic [N*18-1:0] psum_in;
  logic            psum_valid;
  logic            psum_last;
  logic            psum_ready;
  logic [N*18-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            err_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N*18-1:0] pv;

  always #5 clk = ~clk;

  layer11_bias_relu_acc #(.N_adder_tree(N), .MAX_PASSES(16), .ACC_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .bias_in(bias_in), .psum_in(psum_in),
    .psum_valid(psum_valid), .psum_last(psum_last), .psum_ready(psum_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_overrun(err_overrun)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lane(input int i);
    return int'(out_data[18*i +: 18]);
  endfunction

  task automatic push(input logic [N*18-1:0] p, input logic last);
    int n = 0;
    @(negedge clk);
    psum_in = p; psum_last = last; psum_valid = 1'b1;
    while (!psum_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("push_timeout", n, 0);
    @(posedge clk);
    #1 psum_valid = 1'b0; psum_last = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check(tag, int'(out_valid), 1);
  endtask

  task automatic take();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("take_valid_low", int'(out_valid), 0);
    check("take_ready_high", int'(psum_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; psum_valid = 1'b0; psum_last = 1'b0; out_ready = 1'b0;
    psum_in = '0;
    bias_in = '0;
    bias_in[18*0 +: 18] = 18'(8836);
    bias_in[18*3 +: 18] = 18'(-1948);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_psum_ready", int'(psum_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data_nz", int'(|out_data), 0);
    check("rst_err", int'(err_overrun), 0);

    // single beat: lane0 100 + 8836
    pv = '0; pv[18*0 +: 18] = 18'(100);
    push(pv, 1'b1);
    @(negedge clk);
    check("t1_finish_valid", int'(out_valid), 0);
    check("t1_finish_ready", int'(psum_ready), 0);
    @(negedge clk);
    check("t1_out_valid", int'(out_valid), 1);
    check("t1_ready_low", int'(psum_ready), 0);
    check("t1_lane0", lane(0), 8936);
    check("t1_lane1", lane(1), 0);
    take();

    // four beats: lane3 ReLU, lane0 and lane1 independent
    pv = '0;
    pv[18*0 +: 18] = 18'(10);
    pv[18*1 +: 18] = 18'(1000);
    pv[18*3 +: 18] = 18'(-500);
    for (int b = 0; b < 4; b++) push(pv, b == 3);
    wait_out("t2_wait");
    check("t2_lane0", lane(0), 8876);
    check("t2_lane1", lane(1), 4000);
    check("t2_lane3", lane(3), 0);
    take();

    // sixteen beats with last on the final one: positive clamp and exact negative floor
    pv = '0;
    pv[18*5 +: 18] = 18'(131071);
    pv[18*6 +: 18] = 18'(-131072);
    for (int b = 0; b < 16; b++) push(pv, b == 15);
    wait_out("t3_wait");
    check("t3_lane5", lane(5), 131071);
    check("t3_lane6", lane(6), 0);
    check("t3_lane0", lane(0), 8836);
    check("t3_err", int'(err_overrun), 0);
    take();

    // sixteen beats without last: forced finish and sticky error
    pv = '0; pv[18*2 +: 18] = 18'(1);
    for (int b = 0; b < 15; b++) push(pv, 1'b0);
    @(negedge clk);
    check("t4_ready_b15", int'(psum_ready), 1);
    check("t4_err_b15", int'(err_overrun), 0);
    push(pv, 1'b0);
    wait_out("t4_wait");
    check("t4_lane2", lane(2), 16);
    check("t4_err", int'(err_overrun), 1);
    take();
    pv = '0; pv[18*2 +: 18] = 18'(5);
    push(pv, 1'b1);
    wait_out("t4b_wait");
    check("t4b_lane2", lane(2), 5);
    check("t4b_err_sticky", int'(err_overrun), 1);
    take();

    // backpressure with a beat pending
    pv = '0; pv[18*4 +: 18] = 18'(50);
    push(pv, 1'b1);
    wait_out("t5_wait");
    pv = '0; pv[18*4 +: 18] = 18'(3);
    psum_in = pv; psum_last = 1'b1; psum_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_hold_ready", int'(psum_ready), 0);
      check("t5_hold_valid", int'(out_valid), 1);
      check("t5_hold_lane4", lane(4), 50);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t5_post_hs_ready", int'(psum_ready), 1);
    check("t5_post_hs_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 psum_valid = 1'b0; psum_last = 1'b0;
    wait_out("t5b_wait");
    check("t5b_lane4", lane(4), 3);
    take();

    // reset mid-pixel discards the partial sum
    pv = '0; pv[18*7 +: 18] = 18'(1000);
    push(pv, 1'b0);
    push(pv, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_data_nz", int'(|out_data), 0);
    check("t6_rst_err", int'(err_overrun), 0);
    check("t6_rst_ready", int'(psum_ready), 1);
    pv = '0; pv[18*7 +: 18] = 18'(7);
    push(pv, 1'b1);
    wait_out("t6_wait");
    check("t6_lane7", lane(7), 7);
    check("t6_lane0", lane(0), 8836);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
